// File: rtl/soc_config_regs.sv
// SoC configuration registers on APB3: build info, boot address, scratch bank and a
// per-core boot sequencer that raises fetch_enable_o a programmable delay after start.
module soc_config_regs #(
  parameter int unsigned APB_ADDR_WIDTH    = 12,
  parameter int unsigned N_CORES           = 1,
  parameter int unsigned NUM_SCRATCH       = 4,
  parameter logic [31:0] BOOT_ADDR_DEFAULT = 32'h8000,
  parameter int unsigned DATA_RAM_SIZE     = 32768,
  parameter int unsigned INSTR_RAM_SIZE    = 32768,
  parameter int unsigned DELAY_WIDTH       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic                      fetch_en_i,
  output logic [31:0]               boot_addr_o,
  output logic [N_CORES-1:0]        fetch_enable_o
);

  localparam int unsigned ScratchN   = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
  localparam int unsigned ScrIdxW    = (ScratchN > 1) ? $clog2(ScratchN) : 1;
  localparam logic [15:0] DataKb     = 16'(DATA_RAM_SIZE / 1024);
  localparam logic [15:0] InstrKb    = 16'(INSTR_RAM_SIZE / 1024);
  localparam int unsigned IdxInfo    = 0;
  localparam int unsigned IdxBoot    = 1;
  localparam int unsigned IdxDelay   = 2;
  localparam int unsigned IdxCtrl    = 3;
  localparam int unsigned IdxStatus  = 4;
  localparam int unsigned IdxScratch = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDelay = 2'd1,
    StRun   = 2'd2
  } seq_state_e;

  seq_state_e             state_q [N_CORES];
  logic [DELAY_WIDTH-1:0] cnt_q   [N_CORES];
  logic [DELAY_WIDTH-1:0] delay_q;
  logic [29:0]            boot_q;
  logic [31:0]            scratch_q [ScratchN];
  logic                   fe_low_q, fe_low_prev_q;

  logic               access, wr, busy, fe_start, scratch_hit;
  logic [31:0]        widx;
  logic [ScrIdxW-1:0] sidx;
  logic [N_CORES-1:0] start, stop;
  logic [31:0]        status;
  logic               unused_paddr;

  assign access       = PSEL & PENABLE;
  assign wr           = access & PWRITE;
  assign widx         = 32'(PADDR[APB_ADDR_WIDTH-1:2]);
  assign sidx         = ScrIdxW'(widx - IdxScratch);
  assign scratch_hit  = (widx >= IdxScratch) && (widx < IdxScratch + NUM_SCRATCH);
  assign PREADY       = 1'b1;
  assign boot_addr_o  = {boot_q, 2'b00};
  assign unused_paddr = ^PADDR[1:0];

  // The pin is sampled inverted so both flops reset to 0 yet a pin held high through
  // reset reads as "no edge"; a start needs a low sample followed by a high one.
  assign fe_start = fe_low_prev_q & ~fe_low_q;

  always_comb begin
    status      = '0;
    status[7:0] = 8'(fetch_enable_o);
    busy        = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      status[8 + 2*i +: 2] = state_q[i];
      if (state_q[i] != StIdle) busy = 1'b1;
    end
  end

  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (access) begin
      case (widx)
        IdxInfo: begin
          PRDATA  = {DataKb, InstrKb};
          PSLVERR = PWRITE;
        end
        IdxBoot: begin
          PRDATA  = {boot_q, 2'b00};
          PSLVERR = PWRITE & busy;
        end
        IdxDelay: PRDATA = 32'(delay_q);
        IdxCtrl:  ;
        IdxStatus: begin
          PRDATA  = status;
          PSLVERR = PWRITE;
        end
        default: begin
          if (scratch_hit) PRDATA = scratch_q[sidx];
          else             PSLVERR = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    start = '0;
    stop  = '0;
    if (wr && widx == IdxCtrl) begin
      start = PWDATA[N_CORES-1:0];
      stop  = PWDATA[8 +: N_CORES];
    end
    start[0] = start[0] | fe_start;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      boot_q        <= BOOT_ADDR_DEFAULT[31:2];
      delay_q       <= '0;
      fe_low_q      <= 1'b0;
      fe_low_prev_q <= 1'b0;
      for (int i = 0; i < ScratchN; i++) scratch_q[i] <= '0;
    end else begin
      fe_low_q      <= ~fetch_en_i;
      fe_low_prev_q <= fe_low_q;
      if (wr && !PSLVERR) begin
        if (widx == IdxBoot)  boot_q  <= PWDATA[31:2];
        if (widx == IdxDelay) delay_q <= PWDATA[DELAY_WIDTH-1:0];
        if (scratch_hit)      scratch_q[sidx] <= PWDATA;
      end
    end
  end

  // Boot sequencers; stop has priority over start, including a pin-driven start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_enable_o <= '0;
      for (int i = 0; i < N_CORES; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        if (stop[i]) begin
          state_q[i]        <= StIdle;
          cnt_q[i]          <= '0;
          fetch_enable_o[i] <= 1'b0;
        end else begin
          unique case (state_q[i])
            StIdle: begin
              if (start[i]) begin
                state_q[i] <= StDelay;
                cnt_q[i]   <= delay_q;
              end
            end
            StDelay: begin
              if (cnt_q[i] == '0) begin
                state_q[i]        <= StRun;
                fetch_enable_o[i] <= 1'b1;
              end else begin
                cnt_q[i] <= cnt_q[i] - DELAY_WIDTH'(1);
              end
            end
            StRun: ;
            default: begin
              state_q[i]        <= StIdle;
              fetch_enable_o[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_soc_config_regs.sv
// Self-checking bench for soc_config_regs: directed scenarios plus a randomized APB
// sequence scored against a time-based model of the boot sequencers.
module tb_soc_config_regs;
  localparam int NC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [11:0]   PADDR = '0;
  logic [31:0]   PWDATA = '0;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR;
  logic          fetch_en_i = 1'b0;
  logic [31:0]   boot_addr_o;
  logic [NC-1:0] fetch_enable_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: a started core is in DELAY for edges [start, start+delay], RUN afterwards.
  int          start_cyc [NC];
  int          sdelay    [NC];
  logic [31:0] m_delay, m_boot;
  logic [31:0] m_scr [4];

  soc_config_regs #(
    .APB_ADDR_WIDTH(12),
    .N_CORES       (NC),
    .NUM_SCRATCH   (4),
    .DELAY_WIDTH   (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PSEL          (PSEL),
    .PENABLE       (PENABLE),
    .PWRITE        (PWRITE),
    .PADDR         (PADDR),
    .PWDATA        (PWDATA),
    .PRDATA        (PRDATA),
    .PREADY        (PREADY),
    .PSLVERR       (PSLVERR),
    .fetch_en_i    (fetch_en_i),
    .boot_addr_o   (boot_addr_o),
    .fetch_enable_o(fetch_enable_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic int m_state(int i, int c);
    if (start_cyc[i] < 0 || c < start_cyc[i]) return 0;
    if (c <= start_cyc[i] + sdelay[i]) return 1;
    return 2;
  endfunction

  function automatic logic [NC-1:0] m_fetch(int c);
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) r[i] = (m_state(i, c) == 2);
    return r;
  endfunction

  function automatic logic [31:0] m_status(int c);
    logic [31:0] s;
    s = '0;
    s[7:0] = 8'(m_fetch(c));
    for (int i = 0; i < NC; i++) s[8 + 2*i +: 2] = 2'(m_state(i, c));
    return s;
  endfunction

  // Returns 1ns after the commit edge, so cyc then equals that edge's index.
  task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                     output logic [31:0] rdata, output logic err);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(negedge clk);
    PENABLE = 1'b1;
    #1;
    rdata = PRDATA;
    err   = PSLVERR;
    @(posedge clk);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NC; i++) begin
      start_cyc[i] = -1;
      sdelay[i]    = 0;
    end
    for (int i = 0; i < 4; i++) m_scr[i] = '0;
    m_delay = '0;
    m_boot  = 32'h0000_8000;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        er;
    do_reset();
    checks++;
    if (fetch_enable_o !== '0) begin
      errors++; $display("FAIL reset_fetch got %h want 0", fetch_enable_o);
    end
    checks++;
    if (boot_addr_o !== 32'h0000_8000) begin
      errors++; $display("FAIL reset_boot got %h want 00008000", boot_addr_o);
    end
    checks++;
    if ({PRDATA, PSLVERR, PREADY} !== {32'h0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_idle_bus got prdata=%h err=%b rdy=%b want 0/0/1",
                         PRDATA, PSLVERR, PREADY);
    end
    apb(1'b0, 12'h000, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0020_0020 || er !== 1'b0) begin
      errors++; $display("FAIL reset_info got %h err=%b want 00200020 err=0", rd, er);
    end
    apb(1'b0, 12'h004, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0000_8000 || er !== 1'b0) begin
      errors++; $display("FAIL reset_boot_rd got %h err=%b want 00008000 err=0", rd, er);
    end
    apb(1'b0, 12'h010, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL reset_status got %h want 0", rd);
    end
  endtask

  task automatic test_delay_start();
    logic [31:0] rd;
    logic        er;
    int          t, rise;
    do_reset();
    apb(1'b1, 12'h008, 32'd5, rd, er);
    apb(1'b1, 12'h00C, 32'h01, rd, er);
    t = cyc;
    apb(1'b0, 12'h010, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0000_0100) begin
      errors++; $display("FAIL delay_status got %h want 00000100", rd);
    end
    rise = -1;
    for (int k = 0; k < 12 && rise < 0; k++) begin
      if (fetch_enable_o[0]) rise = cyc;
      else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (rise != t + 6) begin
      errors++; $display("FAIL delay_rise got edge %0d want %0d", rise, t + 6);
    end
    apb(1'b0, 12'h010, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0000_0201) begin
      errors++; $display("FAIL run_status got %h want 00000201", rd);
    end
    apb(1'b1, 12'h00C, 32'h0100, rd, er);
    @(posedge clk); #1;
    checks++;
    if (fetch_enable_o !== 2'b00) begin
      errors++; $display("FAIL stop_run got %b want 00", fetch_enable_o);
    end
  endtask

  task automatic test_zero_delay_pair();
    logic [31:0] rd;
    logic        er;
    do_reset();
    apb(1'b1, 12'h008, 32'd0, rd, er);
    apb(1'b1, 12'h00C, 32'h03, rd, er);
    checks++;
    if (fetch_enable_o !== 2'b00) begin
      errors++; $display("FAIL zero_early got %b want 00", fetch_enable_o);
    end
    @(posedge clk); #1;
    checks++;
    if (fetch_enable_o !== 2'b11) begin
      errors++; $display("FAIL zero_rise got %b want 11", fetch_enable_o);
    end
    apb(1'b1, 12'h00C, 32'h0300, rd, er);
    @(posedge clk); #1;
    checks++;
    if (fetch_enable_o !== 2'b00) begin
      errors++; $display("FAIL pair_stop got %b want 00", fetch_enable_o);
    end
    apb(1'b1, 12'h00C, 32'h0101, rd, er);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fetch_enable_o !== 2'b00) begin
      errors++; $display("FAIL stop_wins_fetch got %b want 00", fetch_enable_o);
    end
    apb(1'b1, 12'h00C, 32'h04, rd, er);
    apb(1'b0, 12'h010, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL stop_wins_status got %h want 0", rd);
    end
  endtask

  task automatic test_boot_lock();
    logic [31:0] rd;
    logic        er;
    do_reset();
    apb(1'b1, 12'h008, 32'd0, rd, er);
    apb(1'b1, 12'h00C, 32'h01, rd, er);
    repeat (2) @(posedge clk);
    apb(1'b1, 12'h004, 32'h1C00_0000, rd, er);
    checks++;
    if (er !== 1'b1 || boot_addr_o !== 32'h0000_8000) begin
      errors++; $display("FAIL boot_run_lock got err=%b boot=%h want err=1 boot=00008000",
                         er, boot_addr_o);
    end
    apb(1'b1, 12'h00C, 32'h0100, rd, er);
    apb(1'b1, 12'h004, 32'h1C00_0003, rd, er);
    checks++;
    if (er !== 1'b0 || boot_addr_o !== 32'h1C00_0000) begin
      errors++; $display("FAIL boot_write got err=%b boot=%h want err=0 boot=1c000000",
                         er, boot_addr_o);
    end
    apb(1'b0, 12'h004, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h1C00_0000) begin
      errors++; $display("FAIL boot_readback got %h want 1c000000", rd);
    end
    apb(1'b1, 12'h008, 32'd10, rd, er);
    apb(1'b1, 12'h00C, 32'h02, rd, er);
    apb(1'b1, 12'h004, 32'h0000_2000, rd, er);
    checks++;
    if (er !== 1'b1 || boot_addr_o !== 32'h1C00_0000) begin
      errors++; $display("FAIL boot_delay_lock got err=%b boot=%h want err=1 boot=1c000000",
                         er, boot_addr_o);
    end
  endtask

  task automatic test_map_errors();
    logic [31:0] rd;
    logic        er;
    do_reset();
    apb(1'b1, 12'h000, 32'h1234_5678, rd, er);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL info_write_err got %b want 1", er);
    end
    apb(1'b0, 12'h000, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0020_0020 || er !== 1'b0) begin
      errors++; $display("FAIL info_intact got %h err=%b want 00200020 err=0", rd, er);
    end
    apb(1'b0, 12'h080, 32'h0, rd, er);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL unmapped_read_err got %b want 1", er);
    end
    apb(1'b1, 12'h010, 32'hFFFF_FFFF, rd, er);
    checks++;
    if (er !== 1'b1 || fetch_enable_o !== 2'b00) begin
      errors++; $display("FAIL status_write got err=%b fetch=%b want 1/00", er, fetch_enable_o);
    end
    apb(1'b1, 12'h04C, 32'hDEAD_BEEF, rd, er);
    apb(1'b0, 12'h04C, 32'h0, rd, er);
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      errors++; $display("FAIL scratch3 got %h err=%b want deadbeef err=0", rd, er);
    end
    apb(1'b0, 12'h040, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL scratch0_untouched got %h want 0", rd);
    end
    apb(1'b0, 12'h050, 32'h0, rd, er);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL scratch4_err got %b want 1", er);
    end
    apb(1'b0, 12'h00C, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL ctrl_read got %h err=%b want 0 err=0", rd, er);
    end
    apb(1'b1, 12'h008, 32'hFFFF_FF07, rd, er);
    apb(1'b0, 12'h008, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0000_0007) begin
      errors++; $display("FAIL delay_width got %h want 00000007", rd);
    end
  endtask

  task automatic test_fetch_pin();
    logic [31:0] rd;
    logic        er;
    int          e0, rise;
    fetch_en_i = 1'b1;
    do_reset();
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (fetch_enable_o !== 2'b00) begin
      errors++; $display("FAIL pin_held_fetch got %b want 00", fetch_enable_o);
    end
    apb(1'b0, 12'h010, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL pin_held_status got %h want 0", rd);
    end
    fetch_en_i = 1'b0;
    apb(1'b1, 12'h008, 32'd2, rd, er);
    repeat (2) @(negedge clk);
    fetch_en_i = 1'b1;
    @(posedge clk); #1;
    e0   = cyc;
    rise = -1;
    for (int k = 0; k < 10 && rise < 0; k++) begin
      if (fetch_enable_o[0]) rise = cyc;
      else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (rise != e0 + 4) begin
      errors++; $display("FAIL pin_rise got edge %0d want %0d", rise, e0 + 4);
    end
    fetch_en_i = 1'b0;
    do_reset();
    apb(1'b1, 12'h008, 32'd20, rd, er);
    apb(1'b1, 12'h00C, 32'h01, rd, er);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (fetch_enable_o !== 2'b00) begin
      errors++; $display("FAIL rst_mid_delay got %b want 00", fetch_enable_o);
    end
    @(negedge clk);
    rst = 1'b0;
    apb(1'b0, 12'h010, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL rst_status got %h want 0", rd);
    end
    repeat (25) @(posedge clk);
    #1;
    checks++;
    if (fetch_enable_o !== 2'b00) begin
      errors++; $display("FAIL rst_no_restart got %b want 00", fetch_enable_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, rd, exp;
    logic        er, busy;
    int          op, idx, t;
    do_reset();
    for (int n = 0; n < 200; n++) begin
      op  = $urandom_range(0, 7);
      idx = $urandom_range(0, 3);
      case (op)
        0: begin
          d = $urandom;
          d[7:0] = 8'($urandom_range(0, 6));
          apb(1'b1, 12'h008, d, rd, er);
          m_delay = {24'h0, d[7:0]};
          checks++;
          if (er !== 1'b0) begin
            errors++; $display("FAIL rnd_delay_wr err=%b want 0", er);
          end
        end
        1: begin
          d = $urandom & 32'h0000_0707;
          apb(1'b1, 12'h00C, d, rd, er);
          t = cyc;
          for (int i = 0; i < NC; i++) begin
            if (d[8 + i]) start_cyc[i] = -1;
            else if (d[i] && m_state(i, t - 1) == 0) begin
              start_cyc[i] = t;
              sdelay[i]    = int'(m_delay);
            end
          end
          checks++;
          if (er !== 1'b0) begin
            errors++; $display("FAIL rnd_ctrl_wr err=%b want 0", er);
          end
        end
        2: begin
          apb(1'b0, 12'h010, 32'h0, rd, er);
          exp = m_status(cyc - 1);
          checks++;
          if (rd !== exp || er !== 1'b0) begin
            errors++; $display("FAIL rnd_status got %h err=%b want %h err=0", rd, er, exp);
          end
        end
        3: begin
          d = $urandom;
          apb(1'b1, 12'h004, d, rd, er);
          busy = 1'b0;
          for (int i = 0; i < NC; i++) if (m_state(i, cyc - 1) != 0) busy = 1'b1;
          if (!busy) m_boot = d & 32'hFFFF_FFFC;
          checks++;
          if (er !== busy) begin
            errors++; $display("FAIL rnd_boot_err got %b want %b", er, busy);
          end
        end
        4: begin
          apb(1'b0, 12'h004, 32'h0, rd, er);
          checks++;
          if (rd !== m_boot) begin
            errors++; $display("FAIL rnd_boot_rd got %h want %h", rd, m_boot);
          end
        end
        5: begin
          d = $urandom;
          apb(1'b1, 12'(64 + 4 * idx), d, rd, er);
          m_scr[idx] = d;
          checks++;
          if (er !== 1'b0) begin
            errors++; $display("FAIL rnd_scr_wr err=%b want 0", er);
          end
        end
        6: begin
          if (idx == 3) begin
            apb(1'b0, 12'h008, 32'h0, rd, er);
            exp = m_delay;
          end else begin
            apb(1'b0, 12'(64 + 4 * idx), 32'h0, rd, er);
            exp = m_scr[idx];
          end
          checks++;
          if (rd !== exp) begin
            errors++; $display("FAIL rnd_read idx=%0d got %h want %h", idx, rd, exp);
          end
        end
        default: begin
          repeat ($urandom_range(1, 8)) @(posedge clk);
          #1;
        end
      endcase
      checks++;
      if (fetch_enable_o !== m_fetch(cyc) || boot_addr_o !== m_boot) begin
        errors++; $display("FAIL rnd_outputs n=%0d fetch=%b boot=%h want fetch=%b boot=%h",
                           n, fetch_enable_o, boot_addr_o, m_fetch(cyc), m_boot);
      end
    end
  endtask

  initial begin
    test_reset();
    test_delay_start();
    test_zero_delay_pair();
    test_boot_lock();
    test_map_errors();
    test_fetch_pin();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
